out_port_fifo: RTL
==================

// Module: out_port_fifo
// PURPOSE
// - Parametrised successor to the single-register output port. Captures bus words on out_write into an
//   in-order FIFO and drains them to an external consumer (display/UART/testbench) via valid/ready.
// - Keeps a legacy-style "last written" register so the existing 7-seg/LED path works without change.
// - Sits on the SAP bus beside the A/B/IR registers; driven by the control unit's OUT microinstruction strobe.
// PARAMETERS
// - WIDTH    16  data width of bus, FIFO entries, out_data and last_out
// - DEPTH    8   FIFO entries; power of two, >= 2 (elaboration error otherwise)
// - CNT_W    $clog2(DEPTH+1)  width of count (derived, not overridable)
// PORTS
// - clk        in   1      rising-edge clock
// - rst        in   1      asynchronous, active-high reset
// - bus        in   WIDTH  shared data bus
// - out_write  in   1      push strobe from control unit, sampled at clk rise
// - out_data   out  WIDTH  head-of-FIFO word, valid when out_valid=1
// - out_valid  out  1      FIFO non-empty
// - out_ready  in   1      consumer accepts head when out_valid & out_ready at clk rise
// - last_out   out  WIDTH  last bus word written (legacy output register)
// - full       out  1      count == DEPTH
// - count      out  CNT_W  current occupancy, 0..DEPTH
// - overflow   out  1      sticky: a write was dropped
// - ovf_clr    in   1      clears overflow (sync)
// BEHAVIOUR
// - Reset (async assert, sync-released by clk domain): count=0, out_valid=0, full=0, overflow=0,
//   last_out=0, rd/wr pointers=0, out_data=0. FIFO storage contents are not reset.
// - pop  = out_valid & out_ready.  push = out_write & (~full | pop).
// - Push writes bus into mem[wr_ptr]; wr_ptr++. Pop advances rd_ptr++. Pointers are ADDR_W+1 bits, wrap mod 2*DEPTH;
//   full/empty from MSB-differs/equal comparison; count = wr_ptr - rd_ptr (registered, same value).
// - Latency: a word pushed at edge N is on out_data with out_valid=1 after edge N (visible cycle N+1). No
//   same-cycle bypass: push into empty FIFO never makes out_valid high in the push cycle.
// - out_data: first-word-fall-through; registered head, updated whenever rd_ptr changes or a push hits an empty
//   FIFO; stable while out_valid & ~out_ready (consumer may stall indefinitely). Holds last value when empty.
// - last_out <= bus on every out_write, including dropped writes (matches legacy register semantics).
// - Full + out_write + pop same cycle: push accepted, count unchanged, no overflow.
// - Full + out_write, no pop: word dropped, state unchanged, overflow <= 1 at that edge.
// - Empty + out_ready: no pop, nothing changes. Empty + push + out_ready: push only (out_valid was 0).
// - ovf_clr and a new drop in the same cycle: overflow stays 1 (set wins).
// - count never exceeds DEPTH nor underflows; full == (count==DEPTH); out_valid == (count!=0).
// - rst mid-operation: all queued words discarded immediately; first post-reset push behaves as into empty.
// STRUCTURE
// - Shared package sap_pkg: BUS_W=16 constant, default OUT_DEPTH=8; this block uses them as parameter defaults.
// - One sub-module: out_fifo_ram (DEPTH x WIDTH, 1 write port, 1 async read port, no reset). Pointer,
//   count, flag and head-register logic stays in out_port_fifo.
// TESTING
// - Reset: assert rst mid-run with 3 words queued -> count=0, out_valid=0, overflow=0, last_out=0 same cycle.
// - Ordering: push 0x1111,0x2222,0x3333 with out_ready=0, then out_ready=1 -> out_data 0x1111,0x2222,0x3333
//   on consecutive cycles, out_valid drops after third; count 3->0.
// - Overflow (DEPTH=8): 9 writes 0x0001..0x0009 with out_ready=0 -> full=1, count=8, overflow=1,
//   last_out=0x0009; drain yields 0x0001..0x0008 only; ovf_clr -> overflow=0.
// - Full push+pop: full, out_ready=1 and out_write bus=0xBEEF same cycle -> count stays 8, overflow=0,
//   0xBEEF emerges as 8th word after current head.
// - Wrap/stall: 20 interleaved push/pop with random out_ready stalls -> output stream equals input order,
//   out_data stable whenever out_valid & ~out_ready; run at DEPTH=2 and DEPTH=16, WIDTH=8.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP bus constants; the output port uses them as its parameter defaults.
package sap_pkg;
    localparam int BUS_W     = 16;
    localparam int OUT_DEPTH = 8;
endpackage

// File: rtl/out_port_fifo_if.sv
// Output-port bus bundle: push side from the control unit, drain side to the consumer, status flags.
interface out_port_fifo_if #(
    parameter int WIDTH = sap_pkg::BUS_W,
    parameter int DEPTH = sap_pkg::OUT_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] bus;
    logic             out_write;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] last_out;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             ovf_clr;

    modport slave (
        input  bus, out_write, out_ready, ovf_clr,
        output out_data, out_valid, last_out, full, count, overflow
    );

    modport master (
        output bus, out_write, out_ready, ovf_clr,
        input  out_data, out_valid, last_out, full, count, overflow
    );
endinterface

// File: rtl/out_port_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, contents never reset.
module out_fifo_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/out_port_fifo.sv
// Buffered SAP output port: in-order FIFO with a registered first-word-fall-through head,
// plus the legacy "last written" register and a sticky overflow flag.
module out_port_fifo
    import sap_pkg::*;
#(
    parameter int WIDTH = BUS_W,
    parameter int DEPTH = OUT_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    out_port_fifo_if.slave  port
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = ADDR_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("out_port_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid, r_full, r_ovf;
    logic [WIDTH-1:0] r_head, r_last;

    logic             w_pop, w_push;
    logic [PTR_W-1:0] w_wr_nxt, w_rd_nxt;
    logic             w_full_nxt;
    logic [WIDTH-1:0] w_rdata, w_head_nxt;

    assign w_pop    = r_valid & port.out_ready;
    assign w_push   = port.out_write & (~r_full | w_pop);
    assign w_wr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_push};
    assign w_rd_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_pop};
    assign w_full_nxt = (w_wr_nxt[ADDR_W] != w_rd_nxt[ADDR_W]) &&
                        (w_wr_nxt[ADDR_W-1:0] == w_rd_nxt[ADDR_W-1:0]);

    out_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (port.bus),
        .i_raddr (w_rd_nxt[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    // Head after this edge: the next stored word, or the incoming bus word when
    // it lands in an otherwise-empty queue (the RAM has not captured it yet).
    always_comb begin
        w_head_nxt = r_head;
        if (w_pop) begin
            if (w_rd_nxt != r_wr_ptr) w_head_nxt = w_rdata;
            else if (w_push)          w_head_nxt = port.bus;
        end else if (w_push && !r_valid) begin
            w_head_nxt = port.bus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_head   <= '0;
            r_last   <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= CNT_W'(w_wr_nxt - w_rd_nxt);
            r_valid  <= (w_wr_nxt != w_rd_nxt);
            r_full   <= w_full_nxt;
            r_head   <= w_head_nxt;
            if (port.out_write) r_last <= port.bus;
            // A drop in the same cycle as a clear keeps the flag set.
            if (port.out_write && !w_push) r_ovf <= 1'b1;
            else if (port.ovf_clr)         r_ovf <= 1'b0;
        end
    end

    assign port.out_data  = r_head;
    assign port.out_valid = r_valid;
    assign port.last_out  = r_last;
    assign port.full      = r_full;
    assign port.count     = r_count;
    assign port.overflow  = r_ovf;
endmodule
